// File: rtl/rv_regf_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports, scoreboard and init status.
interface rv_regf_mp_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
);
    logic                   init_busy;
    logic [NRD*5-1:0]       ars;
    logic [NRD*XLEN-1:0]    rs;
    logic [NWR*5-1:0]       awd;
    logic [NWR-1:0]         we;
    logic [NWR*XLEN-1:0]    wd;
    logic                   sb_set;
    logic [4:0]             sb_addr;
    logic [NRD-1:0]         rd_pend;

    modport master (
        input  init_busy, rs, rd_pend,
        output ars, awd, we, wd, sb_set, sb_addr
    );

    modport slave (
        output init_busy, rs, rd_pend,
        input  ars, awd, we, wd, sb_set, sb_addr
    );
endinterface

// File: rtl/rv_regf_mp.sv
// Multi-port integer register file with optional write->read bypass, pending-write
// scoreboard and a one-register-per-cycle clear after reset.
module rv_regf_mp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           xreset,
    rv_regf_mp_if.slave    bus
);
    localparam int unsigned AW = 5;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {ST_CLR, ST_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [AW-1:0]       r_clr_idx, w_clr_idx_nxt;
    logic [XLEN-1:0]     r_regf [1:NREGS-1];
    logic [NREGS-1:1]    r_pend;
    logic [NREGS-1:1]    w_wr_en;
    logic [XLEN-1:0]     w_wr_data [1:NREGS-1];
    logic [NRD*XLEN-1:0] w_rs;
    logic [NRD-1:0]      w_rd_pend;
    logic                w_run;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_state   <= ST_CLR;
            r_clr_idx <= AW'(1);
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Clear walks x1..x(NREGS-1); the index saturates once the last one is cleared.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            ST_CLR: begin
                if (r_clr_idx == LAST_IDX) w_state_nxt = ST_RUN;
                else                       w_clr_idx_nxt = r_clr_idx + AW'(1);
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_CLR;
        endcase
    end

    assign w_run         = (r_state == ST_RUN);
    assign bus.init_busy = ~w_run;

    // Per-register winning write; later ports overwrite earlier ones.
    always_comb begin
        w_wr_en = '0;
        for (int unsigned r = 1; r < NREGS; r++) w_wr_data[r] = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (w_run && bus.we[j] && (bus.awd[j*AW +: AW] == AW'(r))) begin
                    w_wr_en[r]   = 1'b1;
                    w_wr_data[r] = bus.wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (!w_run) begin
                if (r_clr_idx == AW'(r)) r_regf[r] <= '0;
            end else if (w_wr_en[r]) begin
                r_regf[r] <= w_wr_data[r];
            end
        end
    end

    // A new producer issuing in the same cycle as a writeback keeps the register pending.
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_pend <= '0;
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (w_run && bus.sb_set && (bus.sb_addr == AW'(r))) r_pend[r] <= 1'b1;
                else if (w_wr_en[r])                                 r_pend[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rs      = '0;
        w_rd_pend = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (w_run && (bus.ars[i*AW +: AW] == AW'(r))) begin
                    if (BYPASS && w_wr_en[r]) begin
                        w_rs[i*XLEN +: XLEN] = w_wr_data[r];
                        w_rd_pend[i]         = 1'b0;
                    end else begin
                        w_rs[i*XLEN +: XLEN] = r_regf[r];
                        w_rd_pend[i]         = r_pend[r];
                    end
                end
            end
        end
    end

    assign bus.rs      = w_rs;
    assign bus.rd_pend = w_rd_pend;
endmodule
